// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: Y86-64 icodes, status codes and fetch sequencer states
package fetch_pc_ctrl_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    RET_WAIT = 2'd1,
    HOLD     = 2'd2,
    STOP     = 2'd3
  } state_e;
endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: fetch, pipeline-stage and hazard signals around the PC sequencer
interface fetch_pc_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
);
  logic [3:0]        f_icode_i;
  logic [ADDR_W-1:0] f_valC_i;
  logic [ADDR_W-1:0] f_valP_i;
  logic              f_instr_valid_i;
  logic              f_imem_error_i;
  logic              F_stall_i;
  logic [3:0]        M_icode_i;
  logic              M_cnd_i;
  logic [ADDR_W-1:0] M_valA_i;
  logic [3:0]        W_icode_i;
  logic [ADDR_W-1:0] W_valM_i;
  logic [2:0]        W_stat_i;
  logic [ADDR_W-1:0] PC_o;
  logic [ADDR_W-1:0] predPC_o;
  logic [2:0]        f_stat_o;
  logic              fetch_valid_o;
  logic              mispredict_o;
  logic [1:0]        state_o;
  logic [CNT_W-1:0]  instr_cnt_o;
  modport master (
    output f_icode_i, f_valC_i, f_valP_i, f_instr_valid_i, f_imem_error_i, F_stall_i,
           M_icode_i, M_cnd_i, M_valA_i, W_icode_i, W_valM_i, W_stat_i,
    input  PC_o, predPC_o, f_stat_o, fetch_valid_o, mispredict_o, state_o, instr_cnt_o
  );
  modport slave (
    input  f_icode_i, f_valC_i, f_valP_i, f_instr_valid_i, f_imem_error_i, F_stall_i,
           M_icode_i, M_cnd_i, M_valA_i, W_icode_i, W_valM_i, W_stat_i,
    output PC_o, predPC_o, f_stat_o, fetch_valid_o, mispredict_o, state_o, instr_cnt_o
  );
endinterface

// File: rtl/fetch_pc_ctrl_pc_predict.sv
// pc_predict: next-PC prediction (jumps taken, calls to target) and fetch status encoding
module pc_predict
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [3:0]        icode,
  input  logic [ADDR_W-1:0] val_c,
  input  logic [ADDR_W-1:0] val_p,
  input  logic              instr_valid,
  input  logic              imem_error,
  output logic [ADDR_W-1:0] pred_pc,
  output logic [2:0]        stat
);
  always_comb begin
    pred_pc = (icode == IJXX || icode == ICALL) ? val_c : val_p;
    stat    = imem_error ? SADR : !instr_valid ? SINS : icode == IHALT ? SHLT : SAOK;
  end
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: Y86-64 fetch sequencer owning predPC, redirects and fetch suspension
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int                RESET_PC_W = 64,
  parameter logic [RESET_PC_W-1:0] RESET_PC = '0,
  parameter int                ADDR_W   = RESET_PC_W,
  parameter int                CNT_W    = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_pc_ctrl_if.slave bus
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
  logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
  logic [ADDR_W-1:0] pred;
  logic [2:0]        f_stat;
  logic              mispredict, ret_res, redirect, fetch_valid, stop, advance;
  logic [ADDR_W-1:0] pc;
  pc_predict #(.ADDR_W(ADDR_W)) u_predict (
    .icode       (bus.f_icode_i),
    .val_c       (bus.f_valC_i),
    .val_p       (bus.f_valP_i),
    .instr_valid (bus.f_instr_valid_i),
    .imem_error  (bus.f_imem_error_i),
    .pred_pc     (pred),
    .stat        (f_stat)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      pred_pc_q   <= ADDR_W'(RESET_PC);
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pred_pc_q   <= pred_pc_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end
  // A stalled fetch still advances when it is a redirect; a committed fault overrides everything
  always_comb begin
    state_d     = state_q;
    pred_pc_d   = pred_pc_q;
    instr_cnt_d = instr_cnt_q;
    if (stop) begin
      state_d = STOP;
    end else if (advance) begin
      instr_cnt_d = instr_cnt_q + CNT_W'(1);
      state_d     = f_stat != SAOK ? HOLD : bus.f_icode_i == IRET ? RET_WAIT : RUN;
      pred_pc_d   = (f_stat == SAOK && bus.f_icode_i != IRET) ? pred : pred_pc_q;
    end
  end
  always_comb begin
    mispredict  = bus.M_icode_i == IJXX && !bus.M_cnd_i;
    ret_res     = state_q == RET_WAIT && bus.W_icode_i == IRET;
    redirect    = mispredict || ret_res;
    pc          = mispredict ? bus.M_valA_i : ret_res ? bus.W_valM_i : pred_pc_q;
    fetch_valid = state_q != STOP && (state_q == RUN || redirect);
    stop        = bus.W_stat_i != SAOK;
    advance     = fetch_valid && (!bus.F_stall_i || redirect);
  end
  assign bus.PC_o          = pc;
  assign bus.predPC_o      = pred_pc_q;
  assign bus.f_stat_o      = f_stat;
  assign bus.fetch_valid_o = fetch_valid;
  assign bus.mispredict_o  = mispredict && state_q != STOP;
  assign bus.state_o       = state_q;
  assign bus.instr_cnt_o   = instr_cnt_q;
endmodule
